song_sequencer: RTL and testbench
=================================

# song_sequencer

Upstream feeder for the multi-note player. Holds a small writable song memory of 3-bit note numbers and, once started, issues them one at a time over the player's `play_note_val/rdy/num` handshake. Waits for the player to accept each note, then advances. Supports single-pass or looped playback and an immediate stop.

## Interface

Parameters:
- `NUM_ENTRIES`, 16: song memory depth (power of two; index width `$clog2(NUM_ENTRIES)`, 4 at default)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `wr_en` in 1: song memory write enable
- `wr_addr` in 4: write index
- `wr_data` in 3: note number to store (0 = rest, 1–7 = notes)
- `song_len` in 5: number of entries to play, 0..16; values >16 saturate to 16
- `loop` in 1: 1 = wrap to entry 0 after the last entry
- `start` in 1: begin playback, level-sampled each cycle
- `stop` in 1: abort playback, level-sampled each cycle
- `busy` out 1: playback in progress
- `song_idx` out 4: index of the note currently offered
- `play_note_val` out 1: note offered to player
- `play_note_rdy` in 1: player accepts note
- `play_note_num` out 3: note number offered

## Operation

- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: `busy=0`, `play_note_val=0`, `play_note_num=0`, `song_idx=0`, state IDLE, all memory entries 0 (rest).
- States:
  - IDLE: `val=0`, `busy=0`.
  - ISSUE: `val=1`, `busy=1`, `num=mem[idx]`, `song_idx=idx`.
- IDLE→ISSUE: on `start=1 && stop=0 && song_len!=0`. `idx` is loaded with 0.
- Starts that are ignored:
  - `start` with `song_len==0`.
  - `start` while in ISSUE.
- ISSUE, transfer: a transfer occurs on a cycle where `val && rdy`.
  - If `idx != eff_len-1`: `idx←idx+1`, stay in ISSUE.
  - If `idx == eff_len-1` and `loop=1`: `idx←0`, stay in ISSUE.
  - If `idx == eff_len-1` and `loop=0`: go to IDLE, `idx←0`.
- ISSUE, no transfer: hold `idx`. `num` stays stable while `val=1 && rdy=0`.
- `stop=1` in ISSUE: go to IDLE, `idx←0`, regardless of `rdy`.
  - A note offered in that same cycle with `rdy=1` still counts as transferred. The player owns it.
  - Sequencing ends there.
- `stop` and `start` in the same cycle: `stop` wins.
- `eff_len = min(song_len,16)`. It is sampled every cycle, not latched.
  - If `song_len` changes mid-play so that `idx ≥ eff_len-1`, the next transfer is treated as the last one.
  - If `eff_len` becomes 0 while in ISSUE: go to IDLE on the next edge.
- Writes: `mem[wr_addr]←wr_data` on the clock edge, only when `wr_en=1 && busy=0`. Writes while busy are dropped.
- Rest (0) entries are issued like any other note; the player times the rest.
- Index arithmetic: 4-bit, with wrap handled explicitly by the compare. It never overflows into bit 4.

## Timing

- `start` sampled at edge t: `busy=1`, `val=1`, `num=mem[0]` visible after edge t (cycle t+1).
- A transfer at edge t presents `mem[idx+1]` from cycle t+1. Back-to-back transfers are possible, one per cycle, with `val` held high.
- Last transfer at edge t (no loop): `val=0`, `busy=0` from cycle t+1.
- `stop` at edge t: `val=0` from cycle t+1.
- A write at edge t is readable by a `start` sampled at edge t+1.
- `play_note_num` and `song_idx` are combinational from registered state and memory; there is no combinational path from `rdy` to `val` or `num`.
- `rst` asserted mid-play: outputs go to their reset values immediately (asynchronously) and memory is cleared.

## Structure

- Shared package `song_pkg`:
  - `NOTE_REST = 3'd0`
  - `SONG_MAX_LEN = 16`
  - `typedef enum logic {SEQ_IDLE, SEQ_ISSUE} seq_state_t`
- Sub-module `song_mem`: `NUM_ENTRIES`×3 flop array with async-reset-to-0, one write port, one combinational read port.
- Top level: FSM, index register, length saturation/compare.

## Test plan

- Write mem[0..2]=3,5,7; `song_len=3`, `loop=0`; `start` with `rdy` held 1 → `num` 3,5,7 on consecutive cycles with `val=1`; `val=0`, `busy=0` on the 4th cycle.
- Same song with `rdy` pulsed once every 1000 cycles → `num` holds 3 for the full stall; exactly 3 transfers total.
- `loop=1`, `song_len=2` (mem 1,2), `rdy=1` → sequence 1,2,1,2,…; `song_idx` toggles 0,1.
- `stop` raised mid-stall at idx 1 → `val=0` next cycle, `busy=0`, `song_idx=0`; a later `start` replays from entry 0.
- Corner cases:
  - `song_len=0`, then `start` → stays IDLE.
  - `song_len=20` → plays 16 entries.
  - `start` and `stop` together → stays IDLE.
  - `wr_en` while busy → memory unchanged after completion.
- Async `rst` mid-play between edges → `val`/`busy` drop to 0 before the next edge; mem reads 0 (rest) afterwards.

Source files
------------

// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: rest encoding, maximum song length
// and the playback state type.
package song_pkg;

    localparam logic [2:0] NOTE_REST    = 3'd0;
    localparam int         SONG_MAX_LEN = 16;

    typedef enum logic {SEQ_IDLE, SEQ_ISSUE} seq_state_t;

endpackage

// File: rtl/song_mem.sv
// Song memory: NUM_ENTRIES x 3-bit flop array with one write port and one
// combinational read port; the whole array clears to rest on reset.
module song_mem #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_ENTRIES)-1:0] wr_addr,
    input  logic [2:0]                     wr_data,
    input  logic [$clog2(NUM_ENTRIES)-1:0] rd_addr,
    output logic [2:0]                     rd_data
);

    import song_pkg::*;

    logic [2:0] mem [NUM_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem[i] <= NOTE_REST;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: plays the song memory one note at a time over the player's
// val/rdy handshake, with single-pass or looped playback and immediate stop.
module song_sequencer #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_ENTRIES)-1:0] wr_addr,
    input  logic [2:0]                     wr_data,
    input  logic [$clog2(NUM_ENTRIES):0]   song_len,
    input  logic                           loop,
    input  logic                           start,
    input  logic                           stop,
    output logic                           busy,
    output logic [$clog2(NUM_ENTRIES)-1:0] song_idx,
    output logic                           play_note_val,
    input  logic                           play_note_rdy,
    output logic [2:0]                     play_note_num
);

    import song_pkg::*;

    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(NUM_ENTRIES);

    seq_state_t    state;
    logic [IW-1:0] idx;
    logic [LW-1:0] eff_len;
    logic          len_zero;
    logic          at_last;
    logic [2:0]    rd_note;

    // Length is re-evaluated every cycle; >= lets a shrinking song end on the next transfer.
    assign eff_len  = (song_len > MAX_LEN) ? MAX_LEN : song_len;
    assign len_zero = (eff_len == '0);
    assign at_last  = ({1'b0, idx} >= (eff_len - LW'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEQ_IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            play_note_val <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (start && !stop && !len_zero) begin
                        state         <= SEQ_ISSUE;
                        idx           <= '0;
                        busy          <= 1'b1;
                        play_note_val <= 1'b1;
                    end
                end
                SEQ_ISSUE: begin
                    if (stop || len_zero) begin
                        state         <= SEQ_IDLE;
                        idx           <= '0;
                        busy          <= 1'b0;
                        play_note_val <= 1'b0;
                    end else if (play_note_rdy) begin
                        if (at_last) begin
                            idx <= '0;
                            if (!loop) begin
                                state         <= SEQ_IDLE;
                                busy          <= 1'b0;
                                play_note_val <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= SEQ_IDLE;
                    idx           <= '0;
                    busy          <= 1'b0;
                    play_note_val <= 1'b0;
                end
            endcase
        end
    end

    // Memory is frozen during playback so the song cannot change under the player.
    song_mem #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx),
        .rd_data (rd_note)
    );

    assign song_idx      = idx;
    assign play_note_num = play_note_val ? rd_note : NOTE_REST;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: hand-derived vector table, directed
// corner sequences and a randomized run against a behavioural player model.
module tb_song_sequencer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [2:0] wr_data;
    logic [4:0] song_len;
    logic       loop;
    logic       start;
    logic       stop;
    logic       busy;
    logic [3:0] song_idx;
    logic       play_note_val;
    logic       play_note_rdy;
    logic [2:0] play_note_num;

    int checks;
    int errors;
    int dut_xfers;

    // Behavioural model: song contents, playing flag and position in the song.
    int m_mem [16];
    bit m_playing;
    int m_pos;

    typedef struct {
        bit         wr_en;
        logic [3:0] wr_addr;
        logic [2:0] wr_data;
        logic [4:0] song_len;
        bit         loop;
        bit         start;
        bit         stop;
        bit         rdy;
        bit         e_busy;
        bit         e_val;
        logic [3:0] e_idx;
        logic [2:0] e_num;
    } vec_t;

    vec_t vectors [21];

    song_sequencer #(.NUM_ENTRIES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .song_len      (song_len),
        .loop          (loop),
        .start         (start),
        .stop          (stop),
        .busy          (busy),
        .song_idx      (song_idx),
        .play_note_val (play_note_val),
        .play_note_rdy (play_note_rdy),
        .play_note_num (play_note_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_playing = 1'b0;
        m_pos     = 0;
    endtask

    // Advance one clock: the model consumes the same inputs the DUT sees at the edge.
    task automatic tick();
        int eff;
        eff = (int'(song_len) > 16) ? 16 : int'(song_len);
        if (play_note_val && play_note_rdy) dut_xfers++;
        if (rst) begin
            model_reset();
        end else begin
            if (!m_playing && wr_en) m_mem[wr_addr] = int'(wr_data);
            if (m_playing) begin
                if (stop || eff == 0) begin
                    m_playing = 1'b0;
                    m_pos     = 0;
                end else if (play_note_rdy) begin
                    if (m_pos >= eff - 1) begin
                        m_pos     = 0;
                        m_playing = loop;
                    end else begin
                        m_pos = m_pos + 1;
                    end
                end
            end else if (start && !stop && eff > 0) begin
                m_playing = 1'b1;
                m_pos     = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit e_busy, input bit e_val,
                               input logic [3:0] e_idx, input logic [2:0] e_num);
        checks += 4;
        if (busy !== e_busy) begin
            errors++;
            $display("[TB] FAIL %s busy: got %0b want %0b", name, busy, e_busy);
        end
        if (play_note_val !== e_val) begin
            errors++;
            $display("[TB] FAIL %s val: got %0b want %0b", name, play_note_val, e_val);
        end
        if (song_idx !== e_idx) begin
            errors++;
            $display("[TB] FAIL %s song_idx: got %0d want %0d", name, song_idx, e_idx);
        end
        if (play_note_num !== e_num) begin
            errors++;
            $display("[TB] FAIL %s num: got %0d want %0d", name, play_note_num, e_num);
        end
    endtask

    task automatic check_model(input string name);
        checkOutput(name, m_playing, m_playing, 4'(m_pos),
                    m_playing ? 3'(m_mem[m_pos]) : 3'd0);
    endtask

    task automatic check_count(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wr_en         = v.wr_en;
        wr_addr       = v.wr_addr;
        wr_data       = v.wr_data;
        song_len      = v.song_len;
        loop          = v.loop;
        start         = v.start;
        stop          = v.stop;
        play_note_rdy = v.rdy;
        tick();
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; stop = 0; play_note_rdy = 0;
    endtask

    task automatic write_note(input int addr, input int data);
        idle_inputs();
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = 3'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        dut_xfers = 0;
        model_reset();

        //                wr a  d  len lp st sp rdy  busy val idx num
        vectors[0]  = '{1, 0, 3, 0,  0, 0, 0, 0,   0, 0, 0, 0};
        vectors[1]  = '{1, 1, 5, 0,  0, 0, 0, 0,   0, 0, 0, 0};
        vectors[2]  = '{1, 2, 7, 3,  0, 0, 0, 0,   0, 0, 0, 0};
        vectors[3]  = '{0, 0, 0, 3,  0, 1, 0, 1,   1, 1, 0, 3};
        vectors[4]  = '{0, 0, 0, 3,  0, 0, 0, 1,   1, 1, 1, 5};
        vectors[5]  = '{0, 0, 0, 3,  0, 0, 0, 1,   1, 1, 2, 7};
        vectors[6]  = '{0, 0, 0, 3,  0, 0, 0, 1,   0, 0, 0, 0};
        vectors[7]  = '{0, 0, 0, 3,  0, 1, 1, 0,   0, 0, 0, 0};
        vectors[8]  = '{0, 0, 0, 0,  0, 1, 0, 0,   0, 0, 0, 0};
        vectors[9]  = '{0, 0, 0, 2,  1, 1, 0, 0,   1, 1, 0, 3};
        vectors[10] = '{0, 0, 0, 2,  1, 0, 0, 1,   1, 1, 1, 5};
        vectors[11] = '{0, 0, 0, 2,  1, 0, 0, 1,   1, 1, 0, 3};
        vectors[12] = '{0, 0, 0, 2,  1, 0, 0, 1,   1, 1, 1, 5};
        vectors[13] = '{0, 0, 0, 2,  1, 0, 1, 0,   0, 0, 0, 0};
        vectors[14] = '{0, 0, 0, 3,  0, 1, 0, 0,   1, 1, 0, 3};
        vectors[15] = '{1, 0, 6, 3,  0, 0, 0, 0,   1, 1, 0, 3};
        vectors[16] = '{0, 0, 0, 3,  0, 0, 0, 1,   1, 1, 1, 5};
        vectors[17] = '{0, 0, 0, 3,  0, 0, 0, 1,   1, 1, 2, 7};
        vectors[18] = '{0, 0, 0, 3,  0, 0, 0, 1,   0, 0, 0, 0};
        vectors[19] = '{0, 0, 0, 3,  0, 1, 0, 0,   1, 1, 0, 3};
        vectors[20] = '{0, 0, 0, 3,  0, 0, 1, 0,   0, 0, 0, 0};

        rst = 1'b1;
        idle_inputs();
        song_len = 0;
        loop     = 0;
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        checkOutput("reset", 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vectors[i]);
            checkOutput($sformatf("vec%0d", i), vectors[i].e_busy, vectors[i].e_val,
                        vectors[i].e_idx, vectors[i].e_num);
        end

        // Long stalls: the note must hold while rdy is low, one transfer per pulse.
        idle_inputs();
        song_len = 3;
        loop     = 0;
        start    = 1;
        tick();
        start     = 0;
        dut_xfers = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 999; c++) begin
                tick();
                if (c % 100 == 0) check_model($sformatf("stall%0d", p));
            end
            checkOutput($sformatf("stall_end%0d", p), 1, 1, 4'(p), (p == 0) ? 3'd3 : (p == 1) ? 3'd5 : 3'd7);
            play_note_rdy = 1;
            tick();
            play_note_rdy = 0;
        end
        tick();
        tick();
        check_count("stall_xfers", dut_xfers, 3);
        checkOutput("stall_done", 0, 0, 0, 0);

        // Saturated length: 20 requested, 16 played.
        for (int i = 0; i < 16; i++) write_note(i, (i * 3) & 7);
        song_len      = 20;
        loop          = 0;
        start         = 1;
        play_note_rdy = 1;
        tick();
        start     = 0;
        dut_xfers = 0;
        for (int c = 0; c < 20; c++) begin
            check_model("sat_len");
            tick();
        end
        check_count("sat_xfers", dut_xfers, 16);
        checkOutput("sat_done", 0, 0, 0, 0);

        // Asynchronous reset between edges while playing.
        idle_inputs();
        song_len = 3;
        start    = 1;
        tick();
        start = 0;
        checkOutput("pre_rst", 1, 1, 0, 3'd0);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_rst", 0, 0, 0, 0);
        tick();
        #2 rst = 1'b0;
        write_note(5, 6);
        start = 1;
        tick();
        start = 0;
        checkOutput("mem_cleared", 1, 1, 0, 0);
        stop = 1;
        tick();
        stop = 0;

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            wr_en         = ($urandom % 4) == 0;
            wr_addr       = 4'($urandom);
            wr_data       = 3'($urandom);
            start         = ($urandom % 6) == 0;
            stop          = ($urandom % 20) == 0;
            play_note_rdy = ($urandom % 2) == 1;
            if ($urandom % 40 == 0) loop = ~loop;
            if ($urandom % 30 == 0) song_len = 5'($urandom % 32);
            tick();
            check_model("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
